pow_pipe_bp: RTL

- Parametrised successor to the fixed-exponent squaring pipeline.
- Computes o_data = i_base^i_exp mod 2^DW. The exponent is supplied per transaction, so each sample can use a different exponent.
- Uses a square-and-multiply pipeline: one stage per exponent bit, throughput 1/cycle.
- Adds a valid/ready handshake with full-pipeline stall and a per-result overflow flag. Sits between a sample source and any consumer able to apply backpressure.

---
 rtl/pow_pipe_bp.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pow_pipe_bp.sv
// -----------------------------------------------------------------------------
// pow_pipe_bp
//
// Streaming integer power unit: o_data = i_base ** i_exp mod 2**DW, with a
// per-result overflow flag. The exponent travels with each sample, so every
// transaction can use a different exponent. Square-and-multiply is unrolled
// into one pipeline stage per exponent bit, giving a latency of EXP_W cycles
// and a throughput of one sample per cycle.
//
// Flow control is a valid/ready handshake on both sides. When the result in
// the last stage is not accepted, the whole pipeline freezes.
//
// Ports
//   clk      in   1      clock, rising edge
//   rst      in   1      synchronous active-high reset
//   i_valid  in   1      input sample valid
//   i_ready  out  1      input sample accepted this cycle (= !stall)
//   i_base   in   IW     base operand, unsigned
//   i_exp    in   EXP_W  exponent operand, unsigned
//   o_valid  out  1      result valid
//   o_ready  in   1      consumer accepts result this cycle
//   o_data   out  DW     base ** exp truncated to DW bits
//   o_ovf    out  1      true result did not fit in DW bits (with o_valid)
// -----------------------------------------------------------------------------
module pow_pipe_bp #(
    parameter int IW    = 8,
    parameter int EXP_W = 4,
    parameter int DW    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [IW-1:0]    i_base,
    input  logic [EXP_W-1:0] i_exp,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [DW-1:0]    o_data,
    output logic             o_ovf
);

    // Per-stage state. Stage k holds the partial product over exponent bits
    // 0..k (acc), base ** (2 ** (k+1)) truncated (sq), the exponent, a sticky
    // "sq has overflowed" bit (sqo) and the result overflow flag (ovf).
    logic             valid_q [EXP_W];
    logic             valid_d [EXP_W];
    logic [DW-1:0]    acc_q   [EXP_W];
    logic [DW-1:0]    acc_d   [EXP_W];
    logic [DW-1:0]    sq_q    [EXP_W];
    logic [DW-1:0]    sq_d    [EXP_W];
    logic [EXP_W-1:0] e_q     [EXP_W];
    logic [EXP_W-1:0] e_d     [EXP_W];
    logic             sqo_q   [EXP_W];
    logic             sqo_d   [EXP_W];
    logic             ovf_q   [EXP_W];
    logic             ovf_d   [EXP_W];

    logic stall;

    // A stall only arises from an unaccepted result in the last stage; all
    // stages then hold, so no intermediate skid storage is needed.
    always_comb begin
        stall   = valid_q[EXP_W-1] && !o_ready;
        i_ready = !stall;
    end

    genvar gi;
    generate
        for (gi = 0; gi < EXP_W; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_comb begin
                    valid_d[gi] = valid_q[gi];
                    acc_d[gi]   = acc_q[gi];
                    sq_d[gi]    = sq_q[gi];
                    e_d[gi]     = e_q[gi];
                    sqo_d[gi]   = sqo_q[gi];
                    ovf_d[gi]   = ovf_q[gi];
                    if (!stall) begin
                        valid_d[gi] = i_valid;
                        acc_d[gi]   = i_exp[0] ? DW'(i_base) : DW'(1);
                        // base**2 always fits because DW >= 2*IW.
                        sq_d[gi]    = DW'(i_base) * DW'(i_base);
                        e_d[gi]     = i_exp;
                        sqo_d[gi]   = 1'b0;
                        ovf_d[gi]   = 1'b0;
                    end
                end
            end else begin : g_next
                logic [2*DW-1:0] prod;
                logic [2*DW-1:0] sqr;

                always_comb begin
                    prod = {{DW{1'b0}}, acc_q[gi-1]} * {{DW{1'b0}}, sq_q[gi-1]};
                    sqr  = {{DW{1'b0}}, sq_q[gi-1]}  * {{DW{1'b0}}, sq_q[gi-1]};

                    valid_d[gi] = valid_q[gi];
                    acc_d[gi]   = acc_q[gi];
                    sq_d[gi]    = sq_q[gi];
                    e_d[gi]     = e_q[gi];
                    sqo_d[gi]   = sqo_q[gi];
                    ovf_d[gi]   = ovf_q[gi];
                    if (!stall) begin
                        valid_d[gi] = valid_q[gi-1];
                        acc_d[gi]   = e_q[gi-1][gi] ? prod[DW-1:0] : acc_q[gi-1];
                        // Overflow is charged only when a square is actually
                        // multiplied in: either that square was already
                        // truncated, or the product itself spills over.
                        ovf_d[gi]   = ovf_q[gi-1]
                                    | (e_q[gi-1][gi]
                                       & (sqo_q[gi-1] | (prod[2*DW-1:DW] != '0)));
                        sq_d[gi]    = sqr[DW-1:0];
                        sqo_d[gi]   = sqo_q[gi-1] | (sqr[2*DW-1:DW] != '0);
                        e_d[gi]     = e_q[gi-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q[gi] <= 1'b0;
                    acc_q[gi]   <= '0;
                    sq_q[gi]    <= '0;
                    e_q[gi]     <= '0;
                    sqo_q[gi]   <= 1'b0;
                    ovf_q[gi]   <= 1'b0;
                end else begin
                    valid_q[gi] <= valid_d[gi];
                    acc_q[gi]   <= acc_d[gi];
                    sq_q[gi]    <= sq_d[gi];
                    e_q[gi]     <= e_d[gi];
                    sqo_q[gi]   <= sqo_d[gi];
                    ovf_q[gi]   <= ovf_d[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        o_valid = valid_q[EXP_W-1];
        o_data  = acc_q[EXP_W-1];
        o_ovf   = ovf_q[EXP_W-1];
    end

endmodule
